q2_lcd_ctrl: RTL and testbench

Memory-mapped character-display and key-port controller for the q2 12-bit CPU bus at address IO_ADDR. It captures CPU writes to IO_ADDR into a small FIFO and sequences them onto an HD44780-style 8-bit LCD interface (RS/E/D) with enforced pulse and settle timing. After reset it runs a fixed power-on init sequence. CPU reads of IO_ADDR return synchronized active-low key inputs and FIFO status.

---
 rtl/q2_lcd_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_q2_lcd_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q2_lcd_ctrl.sv
// q2 bus character-LCD and key-port controller: queues CPU writes and plays them
// onto an HD44780-style 8-bit interface with fixed pulse/settle timing after a power-on init.
module q2_lcd_ctrl #(
    parameter logic [11:0] IO_ADDR      = 12'hFFF,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          POR_CYCLES   = 16,
    parameter int          E_CYCLES     = 2,
    parameter int          WAIT_CYCLES  = 4,
    parameter int          CLEAR_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] abus,
    input  logic [11:0] dbus_in,
    output logic [11:0] dbus_out,
    output logic        dbus_oe,
    input  logic        wrm,
    input  logic        rdm,
    input  logic [3:0]  keys,
    output logic        lcd_rs,
    output logic        lcd_e,
    output logic [7:0]  lcd_d,
    output logic        busy,
    output logic [2:0]  o_dbg_state
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_POR, S_INIT, S_IDLE, S_SETUP, S_PULSE, S_WAIT
    } state_t;

    state_t        r_state;
    logic [15:0]   r_cnt;
    logic [1:0]    r_init_idx;
    logic          r_init;
    logic          r_lcd_rs;
    logic          r_lcd_e;
    logic [7:0]    r_lcd_d;

    logic          r_wrm_d;
    logic          r_rdm_d;
    logic          r_cap_valid;
    logic [8:0]    r_cap_entry;
    logic [8:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic [3:0]    r_keys_s1;
    logic [3:0]    r_keys_s2;

    logic          w_wr_edge;
    logic          w_rd_edge;
    logic          w_dec_valid;
    logic [8:0]    w_dec_entry;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [8:0]    w_head;
    logic [15:0]   w_wait_last;
    logic          w_wait_done;
    logic          w_unused;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    assign w_unused  = &{1'b0, dbus_in[11:9]};
    assign w_wr_edge = wrm && !r_wrm_d && (abus == IO_ADDR);
    assign w_rd_edge = rdm && !r_rdm_d && (abus == IO_ADDR);

    // Entry format is {rs, d}; command words without a recognised opcode never reach the queue.
    always_comb begin
        w_dec_valid = 1'b1;
        w_dec_entry = {1'b1, dbus_in[7:0]};
        if (dbus_in[8]) begin
            if (dbus_in[7]) begin
                w_dec_entry = {2'b01, dbus_in[6:0]};
            end else if (dbus_in[0]) begin
                w_dec_entry = {1'b0, 8'h01};
            end else begin
                w_dec_valid = 1'b0;
                w_dec_entry = 9'd0;
            end
        end
    end

    assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_head      = r_mem[r_rptr];
    assign w_wait_last = (!r_lcd_rs && r_lcd_d == 8'h01) ? 16'(CLEAR_CYCLES - 1)
                                                         : 16'(WAIT_CYCLES - 1);
    assign w_wait_done = (r_state == S_WAIT) && (r_cnt == w_wait_last);
    assign w_pop       = !w_empty && ((r_state == S_IDLE) || (w_wait_done && !r_init));
    assign w_push      = r_cap_valid && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrm_d     <= 1'b0;
            r_rdm_d     <= 1'b0;
            r_cap_valid <= 1'b0;
            r_cap_entry <= 9'd0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_keys_s1   <= 4'hF;
            r_keys_s2   <= 4'hF;
        end else begin
            r_wrm_d     <= wrm;
            r_rdm_d     <= rdm;
            r_cap_valid <= w_wr_edge && w_dec_valid;
            r_cap_entry <= w_dec_entry;
            r_keys_s1   <= keys;
            r_keys_s2   <= r_keys_s1;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A new drop wins over a read-clear landing on the same edge.
            if (r_cap_valid && w_full && !w_pop) r_ovf <= 1'b1;
            else if (w_rd_edge)                  r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= r_cap_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_POR;
            r_cnt      <= 16'd0;
            r_init_idx <= 2'd0;
            r_init     <= 1'b1;
            r_lcd_rs   <= 1'b0;
            r_lcd_e    <= 1'b0;
            r_lcd_d    <= 8'd0;
        end else begin
            case (r_state)
                S_POR: begin
                    if (r_cnt == 16'(POR_CYCLES - 1)) begin
                        r_cnt   <= 16'd0;
                        r_state <= S_INIT;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_INIT: begin
                    r_lcd_rs <= 1'b0;
                    r_lcd_d  <= init_cmd(r_init_idx);
                    r_state  <= S_SETUP;
                end
                S_IDLE: begin
                    if (!w_empty) begin
                        r_lcd_rs <= w_head[8];
                        r_lcd_d  <= w_head[7:0];
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_lcd_e <= 1'b1;
                    r_cnt   <= 16'd0;
                    r_state <= S_PULSE;
                end
                S_PULSE: begin
                    if (r_cnt == 16'(E_CYCLES - 1)) begin
                        r_lcd_e <= 1'b0;
                        r_cnt   <= 16'd0;
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_WAIT: begin
                    if (w_wait_done) begin
                        r_cnt <= 16'd0;
                        if (r_init) begin
                            if (r_init_idx == 2'd3) begin
                                r_init  <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_init_idx <= r_init_idx + 2'd1;
                                r_lcd_rs   <= 1'b0;
                                r_lcd_d    <= init_cmd(r_init_idx + 2'd1);
                                r_state    <= S_SETUP;
                            end
                        end else if (!w_empty) begin
                            r_lcd_rs <= w_head[8];
                            r_lcd_d  <= w_head[7:0];
                            r_state  <= S_SETUP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= S_POR;
            endcase
        end
    end

    assign lcd_rs      = r_lcd_rs;
    assign lcd_e       = r_lcd_e;
    assign lcd_d       = r_lcd_d;
    assign busy        = !((r_state == S_IDLE) && w_empty);
    assign o_dbg_state = r_state;
    assign dbus_oe     = rdm && (abus == IO_ADDR);
    assign dbus_out    = dbus_oe ? {~w_full, ~r_ovf, 6'b111111, r_keys_s2} : 12'hFFF;
endmodule

// File: tb/tb_q2_lcd_ctrl.sv
// Bench for q2_lcd_ctrl: LCD pulses are scored against an expected queue filled as writes are
// driven; read-port behaviour and the timing corners are checked from tables and short sequences.
module tb_q2_lcd_ctrl;
    localparam int E_CYCLES     = 2;
    localparam int WAIT_CYCLES  = 4;
    localparam int CLEAR_CYCLES = 64;
    localparam int POR_CYCLES   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] abus;
    logic [11:0] dbus_in;
    logic [11:0] dbus_out;
    logic        dbus_oe;
    logic        wrm;
    logic        rdm;
    logic [3:0]  keys;
    logic        lcd_rs;
    logic        lcd_e;
    logic [7:0]  lcd_d;
    logic        busy;
    logic [2:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // Each entry: {expected low cycles before the pulse (0 = any), rs, d}.
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    q2_lcd_ctrl dut (
        .clk(clk), .rst(rst), .abus(abus), .dbus_in(dbus_in), .dbus_out(dbus_out),
        .dbus_oe(dbus_oe), .wrm(wrm), .rdm(rdm), .keys(keys), .lcd_rs(lcd_rs),
        .lcd_e(lcd_e), .lcd_d(lcd_d), .busy(busy), .o_dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pulse monitor and scoreboard consumer.
    logic prev_e = 1'b0;
    int   hi_cnt = 0;
    int   lo_cnt = 0;
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst) begin
            prev_e = 1'b0;
            hi_cnt = 0;
            lo_cnt = 0;
        end else begin
            if (lcd_e) begin
                if (!prev_e) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", {23'd0, lcd_rs, lcd_d}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("lcd_rs_d", {23'd0, lcd_rs, lcd_d}, {23'd0, e[8:0]});
                        if (e[16:9] != 8'd0) check("e_gap", lo_cnt, {24'd0, e[16:9]});
                    end
                    hi_cnt = 1;
                end else begin
                    hi_cnt++;
                end
                lo_cnt = 0;
            end else begin
                if (prev_e) check("e_width", hi_cnt, E_CYCLES);
                lo_cnt++;
            end
            prev_e = lcd_e;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input logic [11:0] addr, input logic [11:0] data);
        @(posedge clk); #1;
        abus = addr; dbus_in = data; wrm = 1'b1;
        @(posedge clk); #1;
        wrm = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        check("idle_reached", ok, 1);
    endtask

    task automatic wait_fall(input int budget, output bit ok);
        bit seen = 0;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (lcd_e) seen = 1;
            else if (seen) begin ok = 1; return; end
        end
    endtask

    task automatic count_busy(input int budget, output int n);
        n = 0;
        while (busy && n < budget) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic push_init();
        exp_q.push_back({8'(POR_CYCLES + 2), 1'b0, 8'h38});
        exp_q.push_back({8'(WAIT_CYCLES + 1), 1'b0, 8'h0C});
        exp_q.push_back({8'(WAIT_CYCLES + 1), 1'b0, 8'h06});
        exp_q.push_back({8'(WAIT_CYCLES + 1), 1'b0, 8'h01});
    endtask

    typedef struct {
        logic [11:0] wdata;
        logic        pulse;
        logic [8:0]  exp;
    } wvec_t;

    typedef struct {
        logic [3:0]  keys;
        logic [11:0] addr;
        logic        rd;
        logic        exp_oe;
        logic [11:0] exp_out;
    } rvec_t;

    wvec_t wv[10];
    rvec_t rv[10];

    initial begin
        bit ok;
        int n;
        logic [3:0] k;

        wv[0] = '{12'h041, 1'b1, {1'b1, 8'h41}};
        wv[1] = '{12'h0FF, 1'b1, {1'b1, 8'hFF}};
        wv[2] = '{12'h2AA, 1'b1, {1'b1, 8'hAA}};
        wv[3] = '{12'h1C5, 1'b1, {1'b0, 8'hC5}};
        wv[4] = '{12'h180, 1'b1, {1'b0, 8'h80}};
        wv[5] = '{12'h1FF, 1'b1, {1'b0, 8'hFF}};
        wv[6] = '{12'h101, 1'b1, {1'b0, 8'h01}};
        wv[7] = '{12'h17F, 1'b1, {1'b0, 8'h01}};
        wv[8] = '{12'h102, 1'b0, 9'd0};
        wv[9] = '{12'h100, 1'b0, 9'd0};

        rv[0] = '{4'hF, 12'hFFF, 1'b1, 1'b1, 12'hFFF};
        rv[1] = '{4'b1011, 12'hFFF, 1'b1, 1'b1, 12'hFFB};
        rv[2] = '{4'b1011, 12'h7FF, 1'b1, 1'b0, 12'hFFF};
        rv[3] = '{4'h0, 12'hFFF, 1'b0, 1'b0, 12'hFFF};
        rv[4] = '{4'h0, 12'hFFF, 1'b1, 1'b1, 12'hFF0};
        rv[5] = '{4'h5, 12'hFFF, 1'b1, 1'b1, 12'hFF5};
        for (int i = 6; i < 10; i++) begin
            k = 4'($urandom_range(0, 15));
            rv[i] = '{k, 12'hFFF, 1'b1, 1'b1, {8'hFF, k}};
        end

        // Reset state, with keys low and a read active to show the synchronizers sit at F.
        rst = 1'b0; abus = 12'hFFF; dbus_in = 12'd0; wrm = 1'b0; rdm = 1'b1; keys = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_lcd_e", lcd_e, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_d", lcd_d, 0);
        check("rst_dbus_oe", dbus_oe, 1);
        check("rst_dbus_out", dbus_out, 12'hFFF);
        rdm = 1'b0; keys = 4'hF;

        // Power-on init: gaps and widths are scored by the monitor.
        push_init();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_fall(400, ok);
            check("init_fall", ok, 1);
        end
        count_busy(400, n);
        check("init_busy_tail", n, CLEAR_CYCLES);
        check("init_idle", busy, 0);

        // Single write latency: edge n -> lcd_e high after edge n+3.
        exp_q.push_back({8'd0, 1'b1, 8'h41});
        @(posedge clk); #1;
        abus = 12'hFFF; dbus_in = 12'h041; wrm = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!lcd_e && n < 20);
        check("write_latency", n, 5);
        wait_fall(20, ok);
        check("single_fall", ok, 1);
        count_busy(100, n);
        check("single_busy_tail", n, WAIT_CYCLES);
        #1 wrm = 1'b0;

        // Decode table.
        for (int i = 0; i < 10; i++) begin
            if (wv[i].pulse) exp_q.push_back({8'd0, wv[i].exp});
            do_write(12'hFFF, wv[i].wdata);
            wait_idle(200);
        end

        // Back-to-back: set-address, clear (long settle), discarded command.
        exp_q.push_back({8'd0, 1'b0, 8'hC5});
        exp_q.push_back({8'(WAIT_CYCLES + 1), 1'b0, 8'h01});
        do_write(12'hFFF, 12'h1C5);
        do_write(12'hFFF, 12'h101);
        do_write(12'hFFF, 12'h102);
        wait_idle(300);

        // Overflow: six writes during a clear's settle time, only four fit.
        exp_q.push_back({8'd0, 1'b0, 8'h01});
        do_write(12'hFFF, 12'h101);
        wait_fall(50, ok);
        check("clear_fall", ok, 1);
        repeat (2) @(posedge clk);
        exp_q.push_back({8'(CLEAR_CYCLES + 1), 1'b1, 8'h30});
        for (int i = 1; i < 4; i++) exp_q.push_back({8'(WAIT_CYCLES + 1), 1'b1, 8'(8'h30 + i)});
        for (int i = 0; i < 6; i++) do_write(12'hFFF, 12'(12'h030 + i));
        @(posedge clk); #1;
        abus = 12'hFFF; rdm = 1'b1;
        @(negedge clk);
        check("ovf_read_oe", dbus_oe, 1);
        check("ovf_read", dbus_out, 12'h3FF);
        @(negedge clk);
        check("ovf_cleared", dbus_out, 12'h7FF);
        #1 rdm = 1'b0;
        wait_idle(400);

        // Write to another address leaves the FIFO untouched.
        do_write(12'h7FF, 12'h041);
        @(negedge clk);
        check("foreign_write_busy", busy, 0);
        repeat (10) @(negedge clk);
        check("foreign_write_busy_late", busy, 0);

        // Read-port table.
        for (int i = 0; i < 10; i++) begin
            keys = rv[i].keys;
            repeat (3) @(posedge clk); #1;
            abus = rv[i].addr; rdm = rv[i].rd;
            @(negedge clk);
            check("rd_oe", dbus_oe, rv[i].exp_oe);
            check("rd_out", dbus_out, rv[i].exp_out);
            #1 rdm = 1'b0;
        end
        keys = 4'hF;

        // Reset while E is high: queued data is lost and init replays.
        exp_q.push_back({8'd0, 1'b1, 8'h41});
        exp_q.push_back({8'd0, 1'b1, 8'h42});
        do_write(12'hFFF, 12'h041);
        do_write(12'hFFF, 12'h042);
        do_write(12'hFFF, 12'h043);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lcd_e && lcd_d == 8'h42) begin ok = 1; break; end
        end
        check("pulse_before_reset", ok, 1);
        #1 rst = 1'b0;
        #1;
        check("midrst_lcd_e", lcd_e, 0);
        check("midrst_busy", busy, 1);
        check("midrst_lcd_d", lcd_d, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        push_init();
        @(posedge clk); #1;
        rst = 1'b1;
        wait_idle(400);
        repeat (30) @(negedge clk);
        check("replay_idle", busy, 0);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
